// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default width, counter
// sizing and the controller state encoding.
package div_pkg;

    // Default operand/quotient/remainder width in bits.
    localparam int unsigned DIV_WIDTH = 32;

    // Counter must be able to hold the value WIDTH itself.
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width for an arbitrary datapath width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: partial remainder P, quotient/shift
// register Q and divisor register. One quotient bit is produced per step.
// The step results are also exported so the controller can capture the
// final quotient/remainder on the same edge as the last step.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_step_o,
    output logic [WIDTH-1:0] q_step_o
);

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_d;

    logic [WIDTH:0]   p_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] p_step_s;
    logic [WIDTH-1:0] q_step_s;

    // One restoring step: shift {P,Q} left, trial-subtract, restore or keep.
    always_comb begin
        p_sh_s  = {p_q, q_q[WIDTH-1]};
        trial_s = p_sh_s - {1'b0, div_q};
        if (trial_s[WIDTH] == 1'b0) begin
            p_step_s = trial_s[WIDTH-1:0];
            q_step_s = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            // Shifted remainder is below the divisor, so its top bit is zero.
            p_step_s = p_sh_s[WIDTH-1:0];
            q_step_s = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register next-state: load operands, advance one step, or hold.
    always_comb begin
        p_d   = p_q;
        q_d   = q_q;
        div_d = div_q;
        if (load_i) begin
            p_d   = {WIDTH{1'b0}};
            q_d   = a_i;
            div_d = b_i;
        end else if (step_i) begin
            p_d   = p_step_s;
            q_d   = q_step_s;
            div_d = div_q;
        end else begin
            p_d   = p_q;
            q_d   = q_q;
            div_d = div_q;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_q   <= {WIDTH{1'b0}};
            q_q   <= {WIDTH{1'b0}};
            div_q <= {WIDTH{1'b0}};
        end else begin
            p_q   <= p_d;
            q_q   <= q_d;
            div_q <= div_d;
        end
    end

    assign p_step_o = p_step_s;
    assign q_step_o = q_step_s;

endmodule

// File: rtl/div_structural.sv
// Sequential unsigned divider (restoring, one quotient bit per clock)
// with a start/ok handshake and a divide-by-zero flag. The controller
// sequences div_datapath and owns the iteration counter and the
// registered result outputs.
module div_structural
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             ok_q;
    logic             ok_d;
    logic             err_q;
    logic             err_d;

    logic             load_s;
    logic             step_s;
    logic [WIDTH-1:0] p_step_s;
    logic [WIDTH-1:0] q_step_s;

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_s),
        .step_i   (step_s),
        .a_i      (A),
        .b_i      (B),
        .p_step_o (p_step_s),
        .q_step_o (q_step_s)
    );

    // Next-state, counter and result logic for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        r_d     = r_q;
        ok_d    = ok_q;
        err_d   = err_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                ok_d  = 1'b0;
                err_d = 1'b0;
                if (start) begin
                    load_s = 1'b1;
                    cnt_d  = CNT_W'(WIDTH);
                    if (B == {WIDTH{1'b0}}) begin
                        // Divide by zero: finish immediately, no iterations.
                        state_d = DONE;
                        d_d     = {WIDTH{1'b1}};
                        r_d     = A;
                        ok_d    = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                step_s = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last step: publish this step's quotient and remainder.
                    state_d = DONE;
                    d_d     = q_step_s;
                    r_d     = p_step_s;
                    ok_d    = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                ok_d    = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Controller and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            r_q     <= r_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign D   = d_q;
    assign R   = r_q;
    assign ok  = ok_q;
    assign err = err_q;

endmodule

// File: tb/tb_div_structural.sv
// Directed and random self-checking bench for div_structural (WIDTH=32).
module tb_div_structural;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] D;
    logic [W-1:0] R;
    logic         ok;
    logic         err;

    int n_checks;
    int n_errors;

    div_structural #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .D     (D),
        .R     (R),
        .ok    (ok),
        .err   (err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a division at the next edge and wait for ok. Edges are counted
    // including the start edge, so a normal division finishes on edge 33
    // and a divide-by-zero on edge 1. A/B are scrambled after capture.
    // Leaves start high and returns at a negedge with ok observed.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_d, input logic [W-1:0] exp_r,
                           input logic exp_err, input int exp_edges);
        int n;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        A = ~a;
        B = b ^ 32'h5A5A_0F0F;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ok) break;
            @(posedge clk);
            n++;
        end
        check({tag, " ok"},      {63'd0, ok},  64'd1);
        check({tag, " edges"},   64'(n),       64'(exp_edges));
        check({tag, " D"},       {32'd0, D},   {32'd0, exp_d});
        check({tag, " R"},       {32'd0, R},   {32'd0, exp_r});
        check({tag, " err"},     {63'd0, err}, {63'd0, exp_err});
    endtask

    // Drop start and confirm return to IDLE with the result held.
    task automatic release_start(input string tag, input logic [W-1:0] exp_d, input logic [W-1:0] exp_r);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle ok"},  {63'd0, ok},  64'd0);
        check({tag, " idle err"}, {63'd0, err}, 64'd0);
        check({tag, " idle D"},   {32'd0, D},   {32'd0, exp_d});
        check({tag, " idle R"},   {32'd0, R},   {32'd0, exp_r});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;

        // Reset held for 10 edges.
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset ok",  {63'd0, ok},  64'd0);
        check("reset err", {63'd0, err}, 64'd0);
        check("reset D",   {32'd0, D},   64'd0);
        check("reset R",   {32'd0, R},   64'd0);

        // Basic: release reset with start already high.
        reset = 1'b1;
        run_div("basic 7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold ok", {63'd0, ok}, 64'd1);
        check("hold D",  {32'd0, D},  64'd3);
        check("hold R",  {32'd0, R},  64'd1);
        release_start("basic", 32'd3, 32'd1);

        // Divide by zero.
        run_div("div0", 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 1);
        release_start("div0", 32'hFFFF_FFFF, 32'd100);

        // Edge operands.
        run_div("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
        release_start("5/9", 32'd0, 32'd5);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        release_start("max/1", 32'hFFFF_FFFF, 32'd0);
        run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
        release_start("max/max", 32'd1, 32'd0);
        run_div("0/13", 32'd0, 32'd13, 32'd0, 32'd0, 1'b0, 33);
        release_start("0/13", 32'd0, 32'd0);

        // Handshake with operands changing during BUSY.
        run_div("1000/7", 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 33);
        release_start("1000/7", 32'd142, 32'd6);

        // Reset in the middle of an operation.
        A     = 32'd7;
        B     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("busy ok", {63'd0, ok}, 64'd0);
        check("busy D held", {32'd0, D}, 64'd142);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst ok",  {63'd0, ok},  64'd0);
        check("midrst err", {63'd0, err}, 64'd0);
        check("midrst D",   {32'd0, D},   64'd0);
        check("midrst R",   {32'd0, R},   64'd0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post-rst ok", {63'd0, ok}, 64'd0);
        run_div("after rst 7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
        release_start("after rst", 32'd3, 32'd1);

        // Random pairs, B never zero; half use small divisors.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            if (i % 2 == 0) begin
                rb = $urandom_range(255, 1);
            end else begin
                rb = $urandom;
                if (rb == 32'd0) rb = 32'd1;
            end
            run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 33);
            start = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
